mult_restore: RTL and testbench



---
 rtl/mult_restore_pkg.sv | 13 +
 rtl/mult_restore.sv | 96 +++++++++
 tb/tb_mult_restore.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mult_restore_pkg.sv
// Shared definitions for the divide/restore pair: one-hot control states and
// the default operand width.
package mult_restore_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    INITIAL = 3'b001,
    COMPUTE = 3'b010,
    DONE_S  = 3'b100
  } state_e;

endpackage : mult_restore_pkg

// File: rtl/mult_restore.sv
// Iterative shift-add multiplier rebuilding a dividend: Product = Qin*Yin + Rin.
// Start/Done/Ack handshake with one-hot INITIAL/COMPUTE/DONE_S control.
module mult_restore
  import mult_restore_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [WIDTH-1:0]   Qin,
  input  logic [WIDTH-1:0]   Yin,
  input  logic [WIDTH-1:0]   Rin,
  input  logic               Start,
  input  logic               Ack,
  output logic               Done,
  output logic [2*WIDTH-1:0] Product
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [2*WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  // Next-state and datapath update for the control unit.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    case (state_q)
      INITIAL: begin
        // Operands are captured every idle cycle; Product tracks Rin until Done.
        a_d    = Qin;
        b_d    = {{WIDTH{1'b0}}, Yin};
        prod_d = {{WIDTH{1'b0}}, Rin};
        cnt_d  = '0;
        if (Start) begin
          state_d = COMPUTE;
        end else begin
          state_d = INITIAL;
        end
      end
      COMPUTE: begin
        if (a_q[0]) begin
          prod_d = prod_q + b_q;
        end else begin
          prod_d = prod_q;
        end
        a_d   = a_q >> 1;
        b_d   = b_q << 1;
        cnt_d = cnt_q + CW'(1);
        // Fixed latency: no early exit when a reaches zero.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE_S;
        end else begin
          state_d = COMPUTE;
        end
      end
      DONE_S: begin
        if (Ack) begin
          state_d = INITIAL;
        end else begin
          state_d = DONE_S;
        end
      end
      default: begin
        state_d = INITIAL;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= INITIAL;
      a_q     <= '0;
      b_q     <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Done    = (state_q == DONE_S);
  assign Product = prod_q;

endmodule : mult_restore

// File: tb/tb_mult_restore.sv
// Directed self-checking bench for mult_restore (WIDTH=4).
module tb_mult_restore;

  localparam int W = 4;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [W-1:0] Qin, Yin, Rin;
  logic         Start, Ack;
  logic         Done;
  logic [2*W-1:0] Product;

  int vectors     = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  mult_restore #(.WIDTH(W)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Qin    (Qin),
    .Yin    (Yin),
    .Rin    (Rin),
    .Start  (Start),
    .Ack    (Ack),
    .Done   (Done),
    .Product(Product)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic scramble_inputs();
    Qin = 4'($urandom);
    Yin = 4'($urandom);
    Rin = 4'($urandom);
  endtask

  // Presents operands with Start for the sampling edge, then walks the
  // remaining WIDTH edges and checks Done/Product.
  task automatic run_op(input string tag, input logic [3:0] q, input logic [3:0] y,
                        input logic [3:0] r, input logic [7:0] exp,
                        input bit scramble, input bit ack_mid);
    Qin = q; Yin = y; Rin = r; Start = 1'b1;
    step();
    Start = 1'b0;
    check({tag, "_busy"}, {7'd0, Done}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      if (scramble) scramble_inputs();
      Ack = (ack_mid && i == 1);
      if (scramble) Start = 1'($urandom);
      step();
    end
    Ack = 1'b0;
    Start = 1'b0;
    check({tag, "_early"}, {7'd0, Done}, 8'd0);
    if (scramble) scramble_inputs();
    step();
    check({tag, "_done"}, {7'd0, Done}, 8'd1);
    check({tag, "_prod"}, Product, exp);
  endtask

  task automatic do_ack(input string tag);
    Ack = 1'b1;
    step();
    Ack = 1'b0;
    check({tag, "_ack"}, {7'd0, Done}, 8'd0);
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Ack = 1'b0;
    Qin = 4'd0; Yin = 4'd0; Rin = 4'd9;
    step();
    check("reset_done", {7'd0, Done}, 8'd0);
    check("reset_prod", Product, 8'd0);
    Reset = 1'b0;
    step();
    check("idle_tracks_rin", Product, 8'd9);

    // Ack in INITIAL has no effect
    Ack = 1'b1; step(); Ack = 1'b0;
    check("ack_idle_done", {7'd0, Done}, 8'd0);

    run_op("basic", 4'd3, 4'd5, 4'd2, 8'h11, 1'b0, 1'b0);
    // Ack held low: result holds
    for (int i = 0; i < 10; i++) begin
      Qin = 4'($urandom); Rin = 4'($urandom); Start = 1'($urandom);
      step();
      check("hold_done", {7'd0, Done}, 8'd1);
      check("hold_prod", Product, 8'h11);
    end
    Start = 1'b0;
    // Reset pulse strictly between edges is invisible
    Reset = 1'b1; #2; Reset = 1'b0;
    step();
    check("glitch_done", {7'd0, Done}, 8'd1);
    check("glitch_prod", Product, 8'h11);
    do_ack("basic");

    run_op("max", 4'd15, 4'd15, 4'd15, 8'd240, 1'b0, 1'b0);
    do_ack("max");
    run_op("q_zero", 4'd0, 4'd9, 4'd7, 8'd7, 1'b0, 1'b0);
    do_ack("q_zero");
    run_op("y_zero", 4'd12, 4'd0, 4'd3, 8'd3, 1'b0, 1'b0);
    do_ack("y_zero");
    run_op("scramble", 4'd7, 4'd6, 4'd4, 8'd46, 1'b1, 1'b0);
    do_ack("scramble");
    run_op("ack_mid", 4'd10, 4'd11, 4'd1, 8'd111, 1'b0, 1'b1);
    do_ack("ack_mid");

    // Start held high across Ack: one INITIAL cycle then the next operation
    Qin = 4'd5; Yin = 4'd13; Rin = 4'd9; Start = 1'b1;
    for (int i = 0; i < 5; i++) step();
    check("held1_done", {7'd0, Done}, 8'd1);
    check("held1_prod", Product, 8'd74);
    Qin = 4'd9; Yin = 4'd9; Rin = 4'd8; Ack = 1'b1;
    step();
    Ack = 1'b0;
    check("held_initial", {7'd0, Done}, 8'd0);
    step();
    check("held_compute", {7'd0, Done}, 8'd0);
    for (int i = 0; i < 4; i++) step();
    check("held2_done", {7'd0, Done}, 8'd1);
    check("held2_prod", Product, 8'd89);
    Start = 1'b0;
    do_ack("held");

    // Reset at the second COMPUTE edge
    Qin = 4'd11; Yin = 4'd13; Rin = 4'd5; Start = 1'b1;
    step();
    Start = 1'b0;
    step();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("midrst_done", {7'd0, Done}, 8'd0);
    check("midrst_prod", Product, 8'd0);
    run_op("after_rst", 4'd2, 4'd7, 4'd6, 8'd20, 1'b0, 1'b0);
    do_ack("after_rst");

    // Divider model feeding the restore path
    for (int x = 0; x < 16; x++) begin
      for (int y = 1; y < 16; y++) begin
        Qin = 4'(x / y); Yin = 4'(y); Rin = 4'(x % y); Start = 1'b1;
        step();
        Start = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check($sformatf("loop_done_%0d_%0d", x, y), {7'd0, Done}, 8'd1);
        check($sformatf("loop_prod_%0d_%0d", x, y), Product, 8'(x));
        Ack = 1'b1; step(); Ack = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_mult_restore
